// File: rtl/ask_symbol_gen_if.sv
// Byte-source handshake into the ASK symbol generator: data, per-byte mode,
// valid from the source, ready back from the generator.
interface ask_symbol_gen_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] mode;

    modport master (
        output in_data,
        output in_valid,
        output mode,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  mode,
        output in_ready
    );
endinterface

// File: rtl/ask_symbol_gen.sv
// Serialises handshaked bytes MSB-first into signed ASK amplitudes
// (OOK / antipodal / Gray 4-level), each held SYM_LEN sample_en ticks.
module ask_symbol_gen #(
    parameter int unsigned SYM_LEN = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sample_en,
    ask_symbol_gen_if.slave in_if,
    output logic [2:0]      base_sig,
    output logic            sym_start,
    output logic            busy,
    output logic            underrun
);
    localparam int unsigned CW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SYM_LEN - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    mode_q, mode_d;
    logic [2:0]    rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    base_q, base_d;
    logic          sym_start_q, sym_start_d;
    logic          underrun_q, underrun_d;

    logic          accept;
    logic          do_load;
    logic [1:0]    load_mode;
    logic [7:0]    next_shift;

    // b holds the top two shift bits; 1-bit modes only look at b[1].
    function automatic logic [2:0] map_sym(input logic [1:0] m, input logic [1:0] b);
        logic [2:0] amp;
        case (m)
            2'b01: amp = b[1] ? 3'b011 : 3'b101;
            2'b10: begin
                case (b)
                    2'b00:   amp = 3'b101;
                    2'b01:   amp = 3'b111;
                    2'b11:   amp = 3'b001;
                    default: amp = 3'b011;
                endcase
            end
            default: amp = b[1] ? 3'b011 : 3'b000;
        endcase
        return amp;
    endfunction

    assign accept = in_if.in_valid & ~hold_full_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        mode_d      = mode_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        sym_start_d = 1'b0;
        underrun_d  = 1'b0;
        do_load     = 1'b0;
        load_mode   = (in_if.mode == 2'b11) ? 2'b00 : in_if.mode;
        next_shift  = (mode_q == 2'b10) ? {shift_q[5:0], 2'b00} : {shift_q[6:0], 1'b0};

        // Accept needs an empty holding register, load needs a full one: never both.
        if (accept) begin
            hold_d      = in_if.in_data;
            hold_full_d = 1'b1;
        end

        if (sample_en) begin
            case (state_q)
                IDLE: do_load = hold_full_q;
                default: begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (rem_q != '0) begin
                        shift_d     = next_shift;
                        base_d      = map_sym(mode_q, next_shift[7:6]);
                        rem_d       = rem_q - 1'b1;
                        cnt_d       = '0;
                        sym_start_d = 1'b1;
                    end else if (hold_full_q) begin
                        do_load = 1'b1;
                    end else begin
                        base_d     = '0;
                        underrun_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            endcase
        end

        if (do_load) begin
            shift_d     = hold_q;
            mode_d      = load_mode;
            rem_d       = (load_mode == 2'b10) ? 3'd3 : 3'd7;
            cnt_d       = '0;
            base_d      = map_sym(load_mode, hold_q[7:6]);
            sym_start_d = 1'b1;
            hold_full_d = 1'b0;
            state_d     = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            mode_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            base_q      <= '0;
            sym_start_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            mode_q      <= mode_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            sym_start_q <= sym_start_d;
            underrun_q  <= underrun_d;
        end
    end

    assign in_if.in_ready = ~hold_full_q;
    assign base_sig       = base_q;
    assign sym_start      = sym_start_q;
    assign underrun       = underrun_q;
    assign busy           = (state_q == RUN);
endmodule

// File: tb/tb_ask_symbol_gen.sv
// Self-checking bench: expected per-tick amplitude stream built from the
// byte/mode list and compared on every clock edge.
module tb_ask_symbol_gen;
    localparam int SL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_en = 1'b0;
    logic [2:0] base_sig;
    logic       sym_start, busy, underrun;

    ask_symbol_gen_if bus ();

    ask_symbol_gen #(.SYM_LEN(SL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .in_if     (bus.slave),
        .base_sig  (base_sig),
        .sym_start (sym_start),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] pend_b[$];
    logic [1:0] pend_m[$];
    logic [2:0] exp_amp[$];
    bit         exp_start[$];
    bit         exp_end[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int level(input logic [1:0] m, input logic [1:0] b);
        case (m)
            2'b01: return b[1] ? 3 : -3;
            2'b10: begin
                case (b)
                    2'b00:   return -3;
                    2'b01:   return -1;
                    2'b11:   return 1;
                    default: return 3;
                endcase
            end
            default: return b[1] ? 3 : 0;
        endcase
    endfunction

    task automatic expect_byte(input logic [7:0] b, input logic [1:0] m);
        int nsym = (m == 2'b10) ? 4 : 8;
        for (int k = 0; k < nsym; k++) begin
            logic [1:0] bits;
            int v;
            if (m == 2'b10) bits = 2'((b >> (6 - 2 * k)) & 8'h03);
            else            bits = {1'((b >> (7 - k)) & 8'h01), 1'b0};
            v = level(m, bits);
            for (int s = 0; s < SL; s++) begin
                exp_amp.push_back(3'(v));
                exp_start.push_back(s == 0);
                exp_end.push_back(1'b0);
            end
        end
    endtask

    task automatic present();
        bus.in_data  = pend_b[0];
        bus.mode     = pend_m[0];
        bus.in_valid = 1'b1;
    endtask

    // se_kind: 0 continuous, 1 every 3rd cycle, 2 random
    task automatic run_stream(input int se_kind);
        logic [2:0] prev;
        logic [2:0] ea;
        bit es, ee, acc;
        bit started = 1'b0;
        int cyc = 0;
        exp_amp.delete();
        exp_start.delete();
        exp_end.delete();
        foreach (pend_b[i]) expect_byte(pend_b[i], pend_m[i]);
        exp_amp.push_back(3'b000);
        exp_start.push_back(1'b0);
        exp_end.push_back(1'b1);
        bus.in_valid = 1'b0;
        if (bus.in_ready && pend_b.size() > 0) present();
        prev = base_sig;
        while (exp_amp.size() > 0 && cyc < 20000) begin
            case (se_kind)
                0:       sample_en = 1'b1;
                1:       sample_en = (cyc % 3 == 2);
                default: sample_en = 1'($urandom_range(0, 1));
            endcase
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (sample_en && started) begin
                ea = exp_amp.pop_front();
                es = exp_start.pop_front();
                ee = exp_end.pop_front();
                chk("base_sig", base_sig, ea);
                chk("sym_start", sym_start, es);
                chk("underrun", underrun, ee);
                chk("busy", busy, !ee);
            end else begin
                chk("hold_base", base_sig, prev);
                chk("idle_sym_start", sym_start, 0);
                chk("idle_underrun", underrun, 0);
            end
            if (acc) begin
                started = 1'b1;
                void'(pend_b.pop_front());
                void'(pend_m.pop_front());
                bus.in_valid = 1'b0;
                chk("ready_after_accept", bus.in_ready, 0);
            end
            if (bus.in_ready && !bus.in_valid && pend_b.size() > 0) present();
            prev = base_sig;
        end
        chk("stream_left", exp_amp.size(), 0);
        sample_en = 1'b0;
        bus.in_valid = 1'b0;
        pend_b.delete();
        pend_m.delete();
    endtask

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.mode     = 2'b00;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_base", base_sig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_sym_start", sym_start, 0);
        chk("rst_underrun", underrun, 0);

        pend_b = {8'hA5};
        pend_m = {2'b00};
        run_stream(0);

        pend_b = {8'h1E};
        pend_m = {2'b10};
        run_stream(0);

        pend_b = {8'hFF, 8'h00};
        pend_m = {2'b01, 2'b01};
        run_stream(0);

        pend_b = {8'h80};
        pend_m = {2'b00};
        run_stream(1);

        // Reset mid-symbol with a second byte waiting in the holding register
        sample_en    = 1'b1;
        bus.in_data  = 8'hFF;
        bus.mode     = 2'b01;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("mid_busy", busy, 1);
        chk("mid_base", base_sig, 3'b011);
        chk("mid_pending", bus.in_ready, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sample_en = 1'b0;
        chk("midrst_base", base_sig, 0);
        chk("midrst_ready", bus.in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_sym_start", sym_start, 0);

        pend_b = {8'h80};
        pend_m = {2'b00};
        run_stream(2);

        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                pend_b.push_back(8'($urandom));
                pend_m.push_back(2'($urandom_range(0, 3)));
            end
            run_stream($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
